// File: rtl/out_feature_writer_pkg.sv
// out_feature_writer_pkg: shared widths, FSM states and layout codes for the output-feature writer
package out_feature_writer_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic {LAYOUT_HWC = 1'b0, LAYOUT_CHW = 1'b1} layout_t;
endpackage

// File: rtl/ofw_pos_counter.sv
// ofw_pos_counter: grp/col/row wrap counters with grp->col->row carry and last-beat flag
module ofw_pos_counter
  import out_feature_writer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic [CNT_W-1:0] grp_last,
  input  logic [CNT_W-1:0] pos_last,
  output logic [CNT_W-1:0] grp,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);
  logic grp_end, col_end, row_end;
  assign grp_end = grp == grp_last;
  assign col_end = col == pos_last;
  assign row_end = row == pos_last;
  assign last = grp_end && col_end && row_end;
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      grp <= '0;
      col <= '0;
      row <= '0;
    end else if (step) begin
      grp <= grp_end ? '0 : grp + 1'b1;
      if (grp_end) col <= col_end ? '0 : col + 1'b1;
      if (grp_end && col_end) row <= row_end ? '0 : row + 1'b1;
    end
  end
endmodule

// File: rtl/out_feature_writer.sv
// out_feature_writer: stream sink that writes 64-bit beats to an output-feature RAM and pulses mLast per frame
module out_feature_writer
  import out_feature_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [CNT_W-1:0]  OutFeature_Size,
  input  logic [CNT_W-1:0]  OutFeature_Channel_Count_Times,
  input  logic              Layout,
  input  logic              sData_valid,
  output logic              sData_ready,
  input  logic [DATA_W-1:0] sData_payload,
  output logic              mem_wr_en,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              mLast
);
  state_t state, state_nx;
  layout_t layout_r;
  logic [ADDR_W-1:0] base_r, sq_r, addr_nx, grp_a, col_a, row_a, size_a, cnt_a;
  logic [CNT_W-1:0] size_r, cnt_r, grp_last, pos_last, grp, col, row;
  logic last_beat, accept, wr_hs, start_ok, zero_cfg;
  assign zero_cfg = OutFeature_Size == '0 || OutFeature_Channel_Count_Times == '0;
  assign start_ok = state == IDLE && start;
  assign wr_hs = mem_wr_en && mem_wr_ready;
  assign sData_ready = state == RUN && (!mem_wr_en || mem_wr_ready);
  assign accept = sData_valid && sData_ready;
  assign busy = state == RUN || state == DRAIN;
  assign mLast = state == DONE;
  assign grp_last = cnt_r - 1'b1;
  assign pos_last = size_r - 1'b1;
  assign grp_a = ADDR_W'(grp);
  assign col_a = ADDR_W'(col);
  assign row_a = ADDR_W'(row);
  assign size_a = ADDR_W'(size_r);
  assign cnt_a = ADDR_W'(cnt_r);
  assign addr_nx = layout_r == LAYOUT_CHW ? base_r + grp_a * sq_r + row_a * size_a + col_a
                                          : base_r + (row_a * size_a + col_a) * cnt_a + grp_a;
  ofw_pos_counter #(.CNT_W(CNT_W)) u_pos (
    .clk(clk),
    .reset(reset),
    .clr(start_ok),
    .step(accept),
    .grp_last(grp_last),
    .pos_last(pos_last),
    .grp(grp),
    .col(col),
    .row(row),
    .last(last_beat)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (zero_cfg ? DONE : RUN) : IDLE)
             : state == RUN ? (accept && last_beat ? DRAIN : RUN)
             : state == DRAIN ? (wr_hs ? DONE : DRAIN)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      layout_r <= LAYOUT_HWC;
      base_r <= '0;
      sq_r <= '0;
      size_r <= '0;
      cnt_r <= '0;
      mem_wr_en <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        layout_r <= layout_t'(Layout);
        base_r <= Base_Addr;
        size_r <= OutFeature_Size;
        cnt_r <= OutFeature_Channel_Count_Times;
        sq_r <= ADDR_W'(OutFeature_Size) * ADDR_W'(OutFeature_Size);
      end
      if (accept) begin
        mem_wr_en <= 1'b1;
        mem_wr_addr <= addr_nx;
        mem_wr_data <= sData_payload;
      end else if (wr_hs) begin
        mem_wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_out_feature_writer.sv
// tb_out_feature_writer: directed self-checking bench for out_feature_writer
`timescale 1ns/1ps
module tb_out_feature_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [31:0] Base_Addr = '0;
  logic [15:0] OutFeature_Size = '0;
  logic [15:0] OutFeature_Channel_Count_Times = '0;
  logic Layout = 1'b0;
  logic sData_valid = 1'b0;
  logic sData_ready;
  logic [63:0] sData_payload = '0;
  logic mem_wr_en;
  logic mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic busy;
  logic mLast;
  logic rdy_bit = 1'b1;
  logic rdy_low = 1'b0;
  logic rand_v = 1'b0;
  logic rand_r = 1'b0;
  int src_limit = 0;
  int acc_total = 0;
  int cyc = 0;
  int mlast_cnt = 0;
  int mlast_cyc = 0;
  int en_cnt = 0;
  int hold_viol = 0;
  logic p_en = 1'b0;
  logic p_rdy = 1'b0;
  logic [31:0] p_addr = '0;
  logic [63:0] p_data = '0;
  logic [31:0] wa[$];
  logic [63:0] wd[$];
  int wc[$];
  int n_assert = 0;
  int n_fail = 0;
  logic seen[18816];
  always #5 clk = ~clk;
  assign mem_wr_ready = rdy_bit && !rdy_low;
  out_feature_writer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Base_Addr(Base_Addr),
    .OutFeature_Size(OutFeature_Size),
    .OutFeature_Channel_Count_Times(OutFeature_Channel_Count_Times),
    .Layout(Layout),
    .sData_valid(sData_valid),
    .sData_ready(sData_ready),
    .sData_payload(sData_payload),
    .mem_wr_en(mem_wr_en),
    .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy(busy),
    .mLast(mLast)
  );
  function automatic logic [63:0] data_of(int i);
    logic [31:0] u;
    u = i;
    return {~u, u + 32'h0000_1000};
  endfunction
  always @(posedge clk) begin
    if (!reset) begin
      if (sData_valid && sData_ready) acc_total++;
      if (mem_wr_en && mem_wr_ready) begin
        wa.push_back(mem_wr_addr);
        wd.push_back(mem_wr_data);
        wc.push_back(cyc);
      end
      if (mem_wr_en) en_cnt++;
      if (mLast) begin
        mlast_cnt++;
        mlast_cyc = cyc;
      end
      if (p_en && !p_rdy && (mem_wr_en !== 1'b1 || mem_wr_addr !== p_addr || mem_wr_data !== p_data)) hold_viol++;
      p_en = mem_wr_en;
      p_rdy = mem_wr_ready;
      p_addr = mem_wr_addr;
      p_data = mem_wr_data;
    end else begin
      p_en = 1'b0;
    end
    cyc++;
  end
  always @(negedge clk) begin
    sData_valid = acc_total < src_limit && (!rand_v || $urandom_range(0, 3) != 0);
    sData_payload = data_of(acc_total);
    rdy_bit = !rand_r || $urandom_range(0, 3) != 0;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_frame(input logic [31:0] base, input int size, input int cnt, input logic lay,
                             input int nbeats, output int b0, output int w0, output int m0);
    step();
    Base_Addr = base;
    OutFeature_Size = 16'(size);
    OutFeature_Channel_Count_Times = 16'(cnt);
    Layout = lay;
    b0 = acc_total;
    w0 = wa.size();
    m0 = mlast_cnt;
    src_limit = acc_total + nbeats;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_mlast(input string tag, input int m0, input int bound);
    int i;
    i = 0;
    while (mlast_cnt == m0 && i < bound) begin
      step();
      i++;
    end
    chk({tag, " mlast_seen"}, 64'(mlast_cnt - m0), 64'd1);
  endtask
  task automatic wait_writes(input string tag, input int n, input int bound);
    int i;
    i = 0;
    while (wa.size() < n && i < bound) begin
      step();
      i++;
    end
    chk({tag, " writes_reached"}, 64'(wa.size() >= n), 64'd1);
  endtask
  task automatic check_linear(input string tag, input int w0, input int b0, input logic [31:0] base);
    chk({tag, " nwr"}, 64'(wa.size() - w0), 64'd12);
    for (int k = 0; k < 12 && w0 + k < wa.size(); k++) begin
      chk($sformatf("%s addr%0d", tag, k), 64'(wa[w0 + k]), 64'(base + k));
      chk($sformatf("%s data%0d", tag, k), wd[w0 + k], data_of(b0 + k));
    end
  endtask
  initial begin
    int b0, w0, m0, e0, dup, oor;
    logic [31:0] h_addr;
    logic [63:0] h_data;
    logic [31:0] chw[12];
    chw = '{32'h100, 32'h104, 32'h108, 32'h101, 32'h105, 32'h109,
            32'h102, 32'h106, 32'h10A, 32'h103, 32'h107, 32'h10B};
    repeat (3) step();
    chk("rst sData_ready", 64'(sData_ready), 64'd0);
    chk("rst mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst mLast", 64'(mLast), 64'd0);
    chk("rst addr", 64'(mem_wr_addr), 64'd0);
    chk("rst data", mem_wr_data, 64'd0);
    reset = 1'b0;
    step();
    start_frame(32'h100, 2, 3, 1'b0, 12, b0, w0, m0);
    chk("t1 busy", 64'(busy), 64'd1);
    wait_mlast("t1", m0, 200);
    check_linear("t1", w0, b0, 32'h100);
    if (wa.size() >= w0 + 12) chk("t1 mlast_timing", 64'(mlast_cyc), 64'(wc[w0 + 11] + 1));
    step();
    chk("t1 mlast_pulse_once", 64'(mlast_cnt - m0), 64'd1);
    chk("t1 idle_busy", 64'(busy), 64'd0);
    start_frame(32'h100, 2, 3, 1'b1, 12, b0, w0, m0);
    wait_mlast("t2", m0, 200);
    chk("t2 nwr", 64'(wa.size() - w0), 64'd12);
    for (int k = 0; k < 12 && w0 + k < wa.size(); k++) begin
      chk($sformatf("t2 addr%0d", k), 64'(wa[w0 + k]), 64'(chw[k]));
      chk($sformatf("t2 data%0d", k), wd[w0 + k], data_of(b0 + k));
    end
    start_frame(32'h100, 2, 3, 1'b0, 12, b0, w0, m0);
    wait_writes("t3", w0 + 4, 100);
    rdy_low = 1'b1;
    step();
    h_addr = mem_wr_addr;
    h_data = mem_wr_data;
    chk("t3 stall_en", 64'(mem_wr_en), 64'd1);
    chk("t3 stall_ready", 64'(sData_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3 hold_addr%0d", k), 64'(mem_wr_addr), 64'(h_addr));
      chk($sformatf("t3 hold_data%0d", k), mem_wr_data, h_data);
      chk($sformatf("t3 hold_ready%0d", k), 64'(sData_ready), 64'd0);
    end
    rdy_low = 1'b0;
    wait_mlast("t3", m0, 200);
    check_linear("t3", w0, b0, 32'h100);
    chk("t3 hold_viol", 64'(hold_viol), 64'd0);
    rand_v = 1'b1;
    rand_r = 1'b1;
    start_frame(32'h2000, 14, 96, 1'b0, 18816, b0, w0, m0);
    wait_mlast("t4", m0, 60000);
    rand_v = 1'b0;
    rand_r = 1'b0;
    step();
    chk("t4 nwr", 64'(wa.size() - w0), 64'd18816);
    dup = 0;
    oor = 0;
    for (int k = 0; k < 18816; k++) seen[k] = 1'b0;
    for (int k = w0; k < wa.size(); k++) begin
      if (wa[k] < 32'h2000 || wa[k] >= 32'h2000 + 18816) oor++;
      else if (seen[wa[k] - 32'h2000]) dup++;
      else seen[wa[k] - 32'h2000] = 1'b1;
    end
    chk("t4 dup_addr", 64'(dup), 64'd0);
    chk("t4 out_of_range", 64'(oor), 64'd0);
    chk("t4 mlast_once", 64'(mlast_cnt - m0), 64'd1);
    chk("t4 hold_viol", 64'(hold_viol), 64'd0);
    e0 = en_cnt;
    start_frame(32'h100, 0, 3, 1'b0, 0, b0, w0, m0);
    chk("t5 mLast_high", 64'(mLast), 64'd1);
    chk("t5 busy_low", 64'(busy), 64'd0);
    step();
    chk("t5 mLast_low", 64'(mLast), 64'd0);
    chk("t5 ready_low", 64'(sData_ready), 64'd0);
    repeat (3) step();
    chk("t5 no_write_en", 64'(en_cnt - e0), 64'd0);
    chk("t5 mlast_once", 64'(mlast_cnt - m0), 64'd1);
    start_frame(32'h100, 2, 0, 1'b0, 0, b0, w0, m0);
    repeat (3) step();
    chk("t5b no_write_en", 64'(en_cnt - e0), 64'd0);
    chk("t5b mlast_once", 64'(mlast_cnt - m0), 64'd1);
    start_frame(32'h100, 2, 3, 1'b0, 12, b0, w0, m0);
    wait_writes("t5c", w0 + 3, 100);
    Base_Addr = 32'h900;
    OutFeature_Size = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_mlast("t5c", m0, 200);
    check_linear("t5c", w0, b0, 32'h100);
    start_frame(32'h100, 2, 3, 1'b0, 12, b0, w0, m0);
    for (int i = 0; i < 100 && acc_total < b0 + 5; i++) step();
    chk("t6 beats_before_reset", 64'(acc_total - b0), 64'd5);
    reset = 1'b1;
    step();
    src_limit = acc_total;
    chk("t6 rst_ready", 64'(sData_ready), 64'd0);
    chk("t6 rst_en", 64'(mem_wr_en), 64'd0);
    chk("t6 rst_busy", 64'(busy), 64'd0);
    chk("t6 rst_mLast", 64'(mLast), 64'd0);
    chk("t6 rst_addr", 64'(mem_wr_addr), 64'd0);
    chk("t6 rst_data", mem_wr_data, 64'd0);
    reset = 1'b0;
    repeat (3) step();
    chk("t6 no_mlast", 64'(mlast_cnt - m0), 64'd0);
    start_frame(32'h100, 2, 3, 1'b0, 12, b0, w0, m0);
    wait_mlast("t6", m0, 200);
    check_linear("t6", w0, b0, 32'h100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
